// File: rtl/fft_cplx_delay_line.sv
// rtl/fft_cplx_delay_line.sv - complex delay line with run-time depth, stall, fill tracking and flush
// Behaves as a D-stage enabled register chain; the last stage is the out_r/out_i register.
module fft_cplx_delay_line #(
  parameter  int WIDTH     = 19,
  parameter  int MAX_DEPTH = 16,
  localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [DW-1:0]    depth,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_r,
  output logic [WIDTH-1:0] out_i,
  output logic             out_valid,
  output logic             cfg_err
);

  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [2*WIDTH-1:0] r_mem [MAX_DEPTH];
  logic [AW-1:0]      r_wp;
  logic [DW-1:0]      r_depth_q;
  logic [DW-1:0]      r_fill;
  logic [WIDTH-1:0]   r_out_r;
  logic [WIDTH-1:0]   r_out_i;
  logic               r_cfg_err;

  logic               w_depth_ok;
  logic [DW-1:0]      w_depth_eff;
  logic [AW+1:0]      w_rd_sum;
  logic [AW-1:0]      w_rd_idx;
  logic [AW-1:0]      w_wp_next;
  logic [2*WIDTH-1:0] w_rd_data;

  assign w_depth_ok  = (depth != '0) && (depth <= DW'(MAX_DEPTH));
  assign w_depth_eff = w_depth_ok ? depth : DW'(MAX_DEPTH);

  // The D-1 stages ahead of the output register live in the ring; the oldest of
  // them sits D-1 slots behind the write pointer, so at D=MAX_DEPTH it is read
  // one slot ahead of the slot being overwritten.
  assign w_rd_sum  = {2'b00, r_wp} + (AW+2)'(MAX_DEPTH + 1) - (AW+2)'(r_depth_q);
  assign w_rd_idx  = (w_rd_sum >= (AW+2)'(MAX_DEPTH)) ? AW'(w_rd_sum - (AW+2)'(MAX_DEPTH))
                                                       : AW'(w_rd_sum);
  assign w_wp_next = (r_wp == AW'(MAX_DEPTH - 1)) ? '0 : r_wp + AW'(1);
  assign w_rd_data = r_mem[w_rd_idx];

  always_ff @(posedge clk) begin
    r_cfg_err <= ~w_depth_ok;
    if (rst) begin
      r_depth_q <= w_depth_eff;
      r_fill    <= '0;
      r_wp      <= '0;
      r_out_r   <= '0;
      r_out_i   <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_fill    <= '0;
      r_wp      <= '0;
      r_out_r   <= '0;
      r_out_i   <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_depth_eff != r_depth_q) begin
      r_depth_q <= w_depth_eff;
      r_fill    <= '0;
    end else if (en) begin
      r_mem[r_wp] <= {in_r, in_i};
      r_wp        <= w_wp_next;
      if (r_depth_q == DW'(1)) begin
        r_out_r <= in_r;
        r_out_i <= in_i;
      end else begin
        r_out_r <= w_rd_data[2*WIDTH-1:WIDTH];
        r_out_i <= w_rd_data[WIDTH-1:0];
      end
      if (r_fill != r_depth_q) r_fill <= r_fill + DW'(1);
    end
  end

  assign out_r     = r_out_r;
  assign out_i     = r_out_i;
  assign out_valid = (r_fill == r_depth_q);
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_fft_cplx_delay_line.sv
// tb/tb_fft_cplx_delay_line.sv - scoreboard bench for fft_cplx_delay_line
module tb_fft_cplx_delay_line;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  depth = 5'd4;
  logic [18:0] in_r = '0;
  logic [18:0] in_i = '0;
  logic [18:0] out_r;
  logic [18:0] out_i;
  logic        out_valid;
  logic        cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [18:0] q[$];
  int          m_d = 16;
  logic [18:0] m_out = '0;
  bit          m_known = 1'b0;
  bit          m_zero_fill = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_cfg = 1'b0;
  int          v = 1;

  fft_cplx_delay_line #(.WIDTH(19), .MAX_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .depth(depth),
    .in_r(in_r), .in_i(in_i), .out_r(out_r), .out_i(out_i),
    .out_valid(out_valid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: drive, let the edge pass, advance the reference model, compare.
  task automatic cyc(input bit e, input bit f, input bit r, input int d, input int val);
    logic [18:0] vr;
    bit          ok;
    int          deff;
    vr = val[18:0];
    rst = r; flush = f; en = e; depth = d[4:0]; in_r = vr; in_i = -vr;
    @(posedge clk);
    #1;
    ok   = (d >= 1) && (d <= 16);
    deff = ok ? d : 16;
    m_cfg = !ok;
    if (r || f) begin
      if (r) m_d = deff;
      q.delete();
      m_out = '0; m_known = 1'b1; m_zero_fill = 1'b1; m_valid = 1'b0;
    end else if (deff != m_d) begin
      m_d = deff;
      q.delete();
      m_valid = 1'b0; m_zero_fill = 1'b0;
    end else if (e) begin
      q.push_back(vr);
      if (q.size() >= m_d) begin
        m_out = q.pop_front(); m_known = 1'b1; m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        if (m_zero_fill) begin m_out = '0; m_known = 1'b1; end
        else m_known = 1'b0;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("cfg_err", 32'(cfg_err), 32'(m_cfg));
    if (m_known) begin
      chk("out_r", 32'(out_r), 32'(m_out));
      chk("out_i", 32'(out_i), 32'(19'(-m_out)));
    end
  endtask

  task automatic beats(input int n, input int d);
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, 1'b0, 1'b0, d, v);
      v++;
    end
  endtask

  initial begin
    // reset then fill at depth 4
    cyc(1'b0, 1'b0, 1'b1, 4, 0);
    beats(10, 4);
    // stall: everything holds
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 4, 32'h5a5a);
    beats(5, 4);
    // depth change 4 -> 8 with en high: sample on that edge is dropped
    cyc(1'b1, 1'b0, 1'b0, 8, 32'h7ffff);
    beats(10, 8);
    // depth 1
    cyc(1'b1, 1'b0, 1'b0, 1, 32'h1111);
    beats(4, 1);
    // depth 16 across pointer wrap, after a flush so the fill reads zeros
    cyc(1'b1, 1'b0, 1'b0, 16, 32'h2222);
    cyc(1'b0, 1'b1, 1'b0, 16, 32'h3333);
    beats(40, 16);
    // out-of-range depth behaves as 16 with cfg_err, no refill
    beats(20, 0);
    beats(4, 20);
    // back to 4, fill, then flush with en high
    cyc(1'b1, 1'b0, 1'b0, 4, 32'h4444);
    beats(6, 4);
    cyc(1'b1, 1'b1, 1'b0, 4, 32'h5555);
    beats(5, 4);
    // mid-fill reset with flush and en high: reset wins
    cyc(1'b0, 1'b1, 1'b0, 4, 0);
    beats(2, 4);
    cyc(1'b1, 1'b1, 1'b1, 4, 32'h6666);
    beats(6, 4);
    // reset while depth port is out of range
    cyc(1'b1, 1'b0, 1'b1, 0, 32'h7777);
    beats(18, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
